// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receiver with 2-flop input synchroniser, mid-bit start
// validation, centre sampling of data and stop bits, and framing-error detection.
//
// Ports:
//   clk_i            system clock, all logic on the rising edge
//   rst_ni           asynchronous active-low reset
//   serial_in_i      raw UART line, idle high, asynchronous to clk_i
//   data_valid_o     one-cycle pulse: received_data_o holds a new good byte
//   received_data_o  last correctly framed byte, held until the next good byte
//   is_receiving_o   high while a frame is in progress (start, data, stop)
//   framing_error_o  one-cycle pulse: stop bit sampled low, byte discarded
module uart_receiver #(
    parameter int unsigned CLKS_PER_BIT = 87
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       serial_in_i,
    output logic       data_valid_o,
    output logic [7:0] received_data_o,
    output logic       is_receiving_o,
    output logic       framing_error_o
);

    localparam logic [7:0] LAST = 8'(CLKS_PER_BIT - 1);
    localparam logic [7:0] HALF = 8'((CLKS_PER_BIT - 1) / 2);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START_BIT = 3'd1,
        DATA_BITS = 3'd2,
        STOP_BIT  = 3'd3,
        CLEANUP   = 3'd4
    } state_e;

    state_e     state_q;
    logic [7:0] cnt_q;
    logic [2:0] idx_q;
    logic [7:0] shift_q;
    logic [7:0] rx_data_q;
    logic       valid_q;
    logic       ferr_q;
    logic       busy_q;
    logic       sync1_q;
    logic       sync2_q;
    logic       rx_sync;

    // Both flops reset high so a reset never looks like a start edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= serial_in_i;
            sync2_q <= sync1_q;
        end
    end

    assign rx_sync = sync2_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            idx_q     <= 3'd0;
            shift_q   <= 8'd0;
            rx_data_q <= 8'd0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q <= 8'd0;
                    idx_q <= 3'd0;
                    if (!rx_sync) begin
                        state_q <= START_BIT;
                        busy_q  <= 1'b1;
                    end
                end
                // A line that is high again at mid start bit was a glitch.
                START_BIT: begin
                    if (cnt_q == HALF) begin
                        cnt_q <= 8'd0;
                        if (!rx_sync) begin
                            state_q <= DATA_BITS;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                // Counter restarts at mid start bit, so each full count lands mid-bit.
                DATA_BITS: begin
                    if (cnt_q == LAST) begin
                        cnt_q          <= 8'd0;
                        shift_q[idx_q] <= rx_sync;
                        if (idx_q == 3'd7) begin
                            idx_q   <= 3'd0;
                            state_q <= STOP_BIT;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                STOP_BIT: begin
                    if (cnt_q == LAST) begin
                        cnt_q   <= 8'd0;
                        busy_q  <= 1'b0;
                        state_q <= CLEANUP;
                        if (rx_sync) begin
                            rx_data_q <= shift_q;
                            valid_q   <= 1'b1;
                        end else begin
                            ferr_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                // Hold here while the line is low so a break cannot retrigger.
                CLEANUP: begin
                    valid_q <= 1'b0;
                    ferr_q  <= 1'b0;
                    if (rx_sync) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= 8'd0;
                    idx_q   <= 3'd0;
                    valid_q <= 1'b0;
                    ferr_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data_valid_o    = valid_q;
    assign received_data_o = rx_data_q;
    assign is_receiving_o  = busy_q;
    assign framing_error_o = ferr_q;

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receiver, the receive-side counterpart of the team's UART transmitter: 8 data bits, LSB first, one start bit, one stop bit, no parity. It synchronises the asynchronous line, validates the start bit at mid-bit, samples each bit at its centre, and checks the stop bit. It presents each byte with a one-cycle valid strobe, or flags a framing error. It sits between the FPGA serial input pin and the sensor command decoder.

## Interface
- CLKS_PER_BIT, 87, clock cycles per UART bit (clock freq / baud); legal range 4..255.
- clock  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- serial_in  in  1  raw UART line, idle high, asynchronous to clock.
- data_valid  out  1  one-cycle pulse: received_data holds a new, correctly framed byte.
- received_data  out  8  last correctly framed byte; held until the next good byte.
- is_receiving  out  1  high while a frame is in progress (START_BIT, DATA_BITS, STOP_BIT).
- framing_error  out  1  one-cycle pulse: stop bit sampled low; byte discarded.

## Operation
- Input sync: two-flop synchroniser serial_in -> rx_sync; both flops reset to 1.
- Counter: 8-bit, counts clock cycles within a bit. H = (CLKS_PER_BIT-1)/2, integer division.
- IDLE: counter=0, bit index=0. If rx_sync==0, go to START_BIT; otherwise stay.
- START_BIT: counter increments each cycle. When counter==H:
  - rx_sync==0: counter<=0, go to DATA_BITS.
  - rx_sync==1: glitch; go to IDLE with no outputs.
- DATA_BITS: counter increments. When counter==CLKS_PER_BIT-1:
  - store rx_sync into shift register bit[index]; counter<=0.
  - index<7: index+1, stay in DATA_BITS.
  - index==7: index<=0, go to STOP_BIT.
- STOP_BIT: when counter==CLKS_PER_BIT-1, sample rx_sync:
  - 1: received_data<=shift register; data_valid<=1.
  - 0: framing_error<=1; received_data unchanged.
  - Then go to CLEANUP.
- CLEANUP: clear data_valid and framing_error. Go to IDLE only when rx_sync==1; otherwise stay, so a break or stuck-low line does not retrigger.
- Unused state encodings return to IDLE.
- data_valid and framing_error are never high together.

## Timing
- Reset (asynchronous assert, effective immediately): state=IDLE, counter=0, index=0, shift register=0x00, received_data=0x00, data_valid=0, framing_error=0, is_receiving=0, sync flops=1.
- Reset mid-frame: frame aborted, no strobe. After deassertion the next frame is received normally.
- Let E0 be the first edge at which sync flop 1 captures 0. rx_sync is low after E1. The IDLE->START_BIT transition occurs at E2.
- Start validation at E(3+H). Data bit k (k=0..7) sampled at E(3+H+(k+1)·CLKS_PER_BIT). Stop bit sampled at E(3+H+9·CLKS_PER_BIT).
- data_valid or framing_error is high for exactly the cycle after the stop-sample edge.
- is_receiving: rises after E2; falls on the stop-sample edge.
- Minimum inter-frame gap: a start edge arriving during CLEANUP (line already high) is detected on the IDLE cycle, so back-to-back frames are supported.
- Tolerated baud mismatch is bounded by centre sampling only; no oversampling or majority vote.

## Test plan
- CLKS_PER_BIT=8. Send 0xA5: data_valid pulses once at E(3+3+72)=E78; received_data=0xA5; framing_error stays 0.
- Back-to-back 0x00 then 0xFF with no idle gap: two data_valid pulses exactly 80 cycles apart; outputs 0x00 then 0xFF.
- Low glitch of 2 cycles on idle line: no is_receiving beyond START_BIT, no strobes, state back in IDLE by E(3+H).
- Send 0x3C with stop bit forced low, then hold the line low for 40 cycles: one framing_error pulse; received_data keeps the prior value; no restart until the line goes high.
- Assert reset_n=0 during data bit 4 of 0x5A: all outputs go to reset values immediately. Then send 0x81: data_valid pulses with 0x81.
- CLKS_PER_BIT=87 with random bytes ×50 from the team UART transmitter in loopback: every byte is matched and no framing errors occur.
